// File: rtl/axis_snapshot_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : axis_snapshot_seq_pkg                                            |
// | Brief   : State encodings shared by the snapshot sequencer and register map|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package axis_snapshot_seq_pkg;

    // Values exposed on sts_state; the register map decodes these directly.
    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_WAIT_TRIG = 2'd1;
    localparam logic [1:0] c_ST_DELAY     = 2'd2;
    localparam logic [1:0] c_ST_HOLD      = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = c_ST_IDLE,
        WAIT_TRIG = c_ST_WAIT_TRIG,
        DELAY     = c_ST_DELAY,
        HOLD      = c_ST_HOLD
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axis_snapshot_seq_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : axis_snapshot_seq_cnt                                            |
// | Brief   : Clear/enable up-counter with equality compare against i_cmp_val  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module axis_snapshot_seq_cnt #(
    parameter int CNTR_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [CNTR_WIDTH-1:0] i_cmp_val,
    output logic                  o_hit
);

    localparam logic [CNTR_WIDTH-1:0] c_ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

    logic [CNTR_WIDTH-1:0] r_count;

    always_ff @(posedge aclk) begin
        if (!aresetn || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_hit = (r_count == i_cmp_val);

endmodule
`default_nettype wire

// File: rtl/axis_snapshot_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : axis_snapshot_seq                                                |
// | Brief   : Armed, triggered single-word AXI4-Stream snapshot sequencer.     |
// |           AXIS_SNAPSHOT_SEQ_TIMEOUT_EN adds a trigger timeout.             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module axis_snapshot_seq
    import axis_snapshot_seq_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32,
    parameter int SNAP_CNT_WIDTH   = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [CNTR_WIDTH-1:0]       cfg_delay,
    input  logic [CNTR_WIDTH-1:0]       cfg_period,
`ifdef AXIS_SNAPSHOT_SEQ_TIMEOUT_EN
    input  logic [CNTR_WIDTH-1:0]       cfg_timeout,
    output logic                        sts_timeout,
`endif
    input  logic                        arm,
    input  logic                        abort,
    input  logic                        trig,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] data,
    output logic                        done,
    output logic [SNAP_CNT_WIDTH-1:0]   snap_count,
    output logic [1:0]                  sts_state
);

    localparam logic [CNTR_WIDTH-1:0]     c_CNT_ONE  = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SNAP_CNT_WIDTH-1:0] c_SNAP_ONE = {{(SNAP_CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                      r_state;
    state_t                      w_next;
    logic                        r_trig_q;
    logic                        w_edge;
    logic                        w_arm_acc;
    logic [CNTR_WIDTH-1:0]       r_delay_lat;
    logic [CNTR_WIDTH-1:0]       r_period_lat;
    logic [AXIS_TDATA_WIDTH-1:0] r_data;
    logic                        r_done;
    logic [SNAP_CNT_WIDTH-1:0]   r_snap_count;
    logic                        w_beat_hit;
    logic                        w_period_hit;
    logic                        w_beat_clr;
    logic                        w_beat_en;
    logic                        w_period_clr;
    logic                        w_period_en;
    logic                        w_capture;
    logic                        w_timeout_fire;

    assign w_edge    = trig & ~r_trig_q;
    assign w_arm_acc = arm & ~abort & ((r_state == IDLE) || (r_state == HOLD));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state  <= IDLE;
            r_trig_q <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_trig_q <= trig;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:      if (arm) w_next = WAIT_TRIG;
                WAIT_TRIG: if (w_edge || w_timeout_fire) w_next = DELAY;
                DELAY:     if (w_capture) w_next = HOLD;
                HOLD: begin
                    if (arm) begin
                        w_next = WAIT_TRIG;
                    end else if ((r_period_lat != '0) && w_period_hit) begin
                        w_next = WAIT_TRIG;
                    end
                end
                default:   w_next = IDLE;
            endcase
        end
    end

    // Each counter is held clear outside its own state, so entry always starts at zero.
    always_comb begin
        w_capture    = (r_state == DELAY) && s_axis_tvalid && w_beat_hit && !abort;
        w_beat_clr   = abort || (r_state != DELAY);
        w_beat_en    = (r_state == DELAY) && s_axis_tvalid && !w_beat_hit;
        w_period_clr = abort || arm || (r_state != HOLD);
        w_period_en  = (r_state == HOLD);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_delay_lat  <= '0;
            r_period_lat <= '0;
        end else if (w_arm_acc) begin
            r_delay_lat  <= cfg_delay;
            r_period_lat <= cfg_period;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_data       <= '0;
            r_done       <= 1'b0;
            r_snap_count <= '0;
        end else begin
            r_done <= w_capture;
            if (w_capture) begin
                r_data       <= s_axis_tdata;
                r_snap_count <= r_snap_count + c_SNAP_ONE;
            end
        end
    end

    axis_snapshot_seq_cnt #(.CNTR_WIDTH(CNTR_WIDTH)) u_beat_cnt (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_clr     (w_beat_clr),
        .i_en      (w_beat_en),
        .i_cmp_val (r_delay_lat),
        .o_hit     (w_beat_hit)
    );

    // HOLD lasts period_lat cycles: the count starts at 0 on entry, so compare one early.
    axis_snapshot_seq_cnt #(.CNTR_WIDTH(CNTR_WIDTH)) u_period_cnt (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_clr     (w_period_clr),
        .i_en      (w_period_en),
        .i_cmp_val (r_period_lat - c_CNT_ONE),
        .o_hit     (w_period_hit)
    );

`ifdef AXIS_SNAPSHOT_SEQ_TIMEOUT_EN
    logic [CNTR_WIDTH-1:0] r_timeout_lat;
    logic                  r_sts_timeout;
    logic                  w_tmo_hit;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_timeout_lat <= '0;
        end else if (w_arm_acc) begin
            r_timeout_lat <= cfg_timeout;
        end
    end

    axis_snapshot_seq_cnt #(.CNTR_WIDTH(CNTR_WIDTH)) u_timeout_cnt (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_clr     (abort || (r_state != WAIT_TRIG)),
        .i_en      (r_state == WAIT_TRIG),
        .i_cmp_val (r_timeout_lat - c_CNT_ONE),
        .o_hit     (w_tmo_hit)
    );

    assign w_timeout_fire = (r_state == WAIT_TRIG) && (r_timeout_lat != '0) && w_tmo_hit && !w_edge;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_sts_timeout <= 1'b0;
        end else if (abort || w_arm_acc) begin
            r_sts_timeout <= 1'b0;
        end else if (w_timeout_fire) begin
            r_sts_timeout <= 1'b1;
        end
    end

    assign sts_timeout = r_sts_timeout;
`else
    assign w_timeout_fire = 1'b0;
`endif

    assign s_axis_tready = 1'b1;
    assign data          = r_data;
    assign done          = r_done;
    assign snap_count    = r_snap_count;
    assign sts_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_axis_snapshot_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_axis_snapshot_seq                                             |
// | Brief   : Scoreboard bench for axis_snapshot_seq (narrow counters for      |
// |           cheap boundary cases; AXIS_SNAPSHOT_SEQ_TIMEOUT_EN optional)     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_axis_snapshot_seq;
    import axis_snapshot_seq_pkg::*;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int SW = 4;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [CW-1:0] cfg_delay = '0;
    logic [CW-1:0] cfg_period = '0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          trig = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] data;
    logic          done;
    logic [SW-1:0] snap_count;
    logic [1:0]    sts_state;
`ifdef AXIS_SNAPSHOT_SEQ_TIMEOUT_EN
    logic [CW-1:0] cfg_timeout = '0;
    logic          sts_timeout;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int pulses  = 0;

    logic [DW-1:0] q_data[$];
    logic [SW-1:0] q_snap[$];
    logic [SW-1:0] model_snap = '0;
    logic [DW-1:0] last_data  = '0;

    axis_snapshot_seq #(
        .AXIS_TDATA_WIDTH (DW),
        .CNTR_WIDTH       (CW),
        .SNAP_CNT_WIDTH   (SW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_delay     (cfg_delay),
        .cfg_period    (cfg_period),
`ifdef AXIS_SNAPSHOT_SEQ_TIMEOUT_EN
        .cfg_timeout   (cfg_timeout),
        .sts_timeout   (sts_timeout),
`endif
        .arm           (arm),
        .abort         (abort),
        .trig          (trig),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .data          (data),
        .done          (done),
        .snap_count    (snap_count),
        .sts_state     (sts_state)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock; any done pulse is popped from the scoreboard and compared.
    task automatic step();
        logic [DW-1:0] exp_d;
        logic [SW-1:0] exp_s;
        @(posedge aclk);
        #1;
        if (done === 1'b1) begin
            pulses++;
            n_total++;
            if (q_data.size() == 0) begin
                $display("FAIL unexpected_done data=%h snap=%0d (no capture expected)", data, snap_count);
            end else begin
                exp_d = q_data.pop_front();
                exp_s = q_snap.pop_front();
                if (data !== exp_d || snap_count !== exp_s)
                    $display("FAIL capture data=%h snap=%0d expected data=%h snap=%0d",
                             data, snap_count, exp_d, exp_s);
                else
                    n_pass++;
            end
        end
    endtask

    task automatic expect_capture(input logic [DW-1:0] d);
        model_snap = model_snap + 1'b1;
        last_data  = d;
        q_data.push_back(d);
        q_snap.push_back(model_snap);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic do_trig();
        trig = 1'b1;
        step();
        trig = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        step();
        step();
        aresetn = 1'b1;
        n_total++; if (sts_state !== c_ST_IDLE) $display("FAIL reset_state got %0d want %0d", sts_state, c_ST_IDLE); else n_pass++;
        n_total++; if (data !== '0) $display("FAIL reset_data got %h want 0", data); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_total++; if (snap_count !== '0) $display("FAIL reset_snap got %0d want 0", snap_count); else n_pass++;
        n_total++; if (s_axis_tready !== 1'b1) $display("FAIL tready got %b want 1", s_axis_tready); else n_pass++;
    endtask

    task automatic test_single_shot();
        cfg_delay  = '0;
        cfg_period = '0;
        do_arm();
        n_total++; if (sts_state !== c_ST_WAIT_TRIG) $display("FAIL ss_arm state got %0d want %0d", sts_state, c_ST_WAIT_TRIG); else n_pass++;
        repeat (4) step();
        n_total++; if (sts_state !== c_ST_WAIT_TRIG) $display("FAIL ss_wait state got %0d want %0d", sts_state, c_ST_WAIT_TRIG); else n_pass++;
        do_trig();
        n_total++; if (sts_state !== c_ST_DELAY) $display("FAIL ss_trig state got %0d want %0d", sts_state, c_ST_DELAY); else n_pass++;
        step();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hA5A5_0001;
        expect_capture(32'hA5A5_0001);
        step();
        s_axis_tvalid = 1'b0;
        n_total++; if (done !== 1'b1) $display("FAIL ss_done got %b want 1", done); else n_pass++;
        n_total++; if (sts_state !== c_ST_HOLD) $display("FAIL ss_hold state got %0d want %0d", sts_state, c_ST_HOLD); else n_pass++;
        step();
        n_total++; if (done !== 1'b0) $display("FAIL ss_done_pulse got %b want 0", done); else n_pass++;
        repeat (8) step();
        n_total++; if (sts_state !== c_ST_HOLD) $display("FAIL ss_hold_held state got %0d want %0d", sts_state, c_ST_HOLD); else n_pass++;
    endtask

    task automatic test_delay_gaps();
        logic [5:0] vpat;
        vpat = 6'b101101;
        cfg_delay = 8'd3;
        do_arm();
        cfg_delay = 8'd0;
        do_trig();
        pulses = 0;
        expect_capture(32'd6);
        for (int i = 0; i < 6; i++) begin
            s_axis_tvalid = vpat[5-i];
            s_axis_tdata  = 32'(i + 1);
            step();
        end
        s_axis_tvalid = 1'b0;
        step();
        step();
        n_total++; if (pulses !== 1) $display("FAIL gaps_pulses got %0d want 1", pulses); else n_pass++;
        n_total++; if (data !== 32'd6) $display("FAIL gaps_data got %h want 6", data); else n_pass++;
        n_total++; if (sts_state !== c_ST_HOLD) $display("FAIL gaps_state got %0d want %0d", sts_state, c_ST_HOLD); else n_pass++;
    endtask

    task automatic test_periodic();
        int hc;
        cfg_delay  = '0;
        cfg_period = 8'd20;
        do_arm();
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_axis_tdata = 32'h100 + 32'(i);
            do_trig();
            expect_capture(32'h100 + 32'(i));
            step();
            s_axis_tdata = 32'hFFFF_0000;
            hc = 0;
            while (sts_state === c_ST_HOLD && hc < 60) begin
                hc++;
                step();
            end
            n_total++; if (hc !== 20) $display("FAIL per_hold_len[%0d] got %0d want 20", i, hc); else n_pass++;
            n_total++; if (sts_state !== c_ST_WAIT_TRIG) $display("FAIL per_rearm[%0d] got %0d want %0d", i, sts_state, c_ST_WAIT_TRIG); else n_pass++;
            repeat (50 - 22) step();
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_abort_arm();
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_total++; if (sts_state !== c_ST_IDLE) $display("FAIL abort_wait got %0d want %0d", sts_state, c_ST_IDLE); else n_pass++;
        cfg_period = '0;
        cfg_delay  = 8'd5;
        do_arm();
        do_trig();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hBAD0_0001;
        step();
        step();
        abort = 1'b1;
        arm   = 1'b1;
        step();
        abort = 1'b0;
        arm   = 1'b0;
        n_total++; if (sts_state !== c_ST_IDLE) $display("FAIL abort_arm state got %0d want %0d", sts_state, c_ST_IDLE); else n_pass++;
        pulses = 0;
        repeat (3) step();
        do_trig();
        repeat (10) step();
        s_axis_tvalid = 1'b0;
        n_total++; if (pulses !== 0) $display("FAIL abort_nocap pulses got %0d want 0", pulses); else n_pass++;
        n_total++; if (sts_state !== c_ST_IDLE) $display("FAIL abort_idle got %0d want %0d", sts_state, c_ST_IDLE); else n_pass++;
        n_total++; if (data !== last_data) $display("FAIL abort_data got %h want %h", data, last_data); else n_pass++;
        n_total++; if (snap_count !== model_snap) $display("FAIL abort_snap got %0d want %0d", snap_count, model_snap); else n_pass++;
    endtask

    task automatic test_reset_mid_delay();
        cfg_delay = '0;
        do_arm();
        do_trig();
        n_total++; if (sts_state !== c_ST_DELAY) $display("FAIL rst_pre state got %0d want %0d", sts_state, c_ST_DELAY); else n_pass++;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hDEAD_BEEF;
        aresetn = 1'b0;
        model_snap = '0;
        last_data  = '0;
        step();
        aresetn = 1'b1;
        s_axis_tvalid = 1'b0;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
        n_total++; if (data !== '0) $display("FAIL rst_data got %h want 0", data); else n_pass++;
        n_total++; if (snap_count !== '0) $display("FAIL rst_snap got %0d want 0", snap_count); else n_pass++;
        n_total++; if (sts_state !== c_ST_IDLE) $display("FAIL rst_state got %0d want %0d", sts_state, c_ST_IDLE); else n_pass++;
        step();
        n_total++; if (done !== 1'b0) $display("FAIL rst_done_after got %b want 0", done); else n_pass++;
    endtask

    task automatic test_max_delay();
        int early;
        cfg_delay  = 8'hFF;
        cfg_period = '0;
        do_arm();
        do_trig();
        pulses = 0;
        early  = 0;
        s_axis_tvalid = 1'b1;
        for (int k = 0; k < 256; k++) begin
            s_axis_tdata = 32'h1000 + 32'(k);
            if (k == 255) begin
                early = pulses;
                expect_capture(32'h1000 + 32'(k));
            end
            step();
        end
        s_axis_tvalid = 1'b0;
        n_total++; if (early !== 0) $display("FAIL maxdly_early got %0d want 0", early); else n_pass++;
        n_total++; if (sts_state !== c_ST_HOLD) $display("FAIL maxdly_state got %0d want %0d", sts_state, c_ST_HOLD); else n_pass++;
    endtask

    task automatic test_back_to_back();
        cfg_delay = '0;
        pulses = 0;
        for (int i = 0; i < 17; i++) begin
            do_arm();
            do_trig();
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'h2000 + 32'(i);
            expect_capture(32'h2000 + 32'(i));
            step();
            s_axis_tvalid = 1'b0;
        end
        step();
        n_total++; if (pulses !== 17) $display("FAIL b2b_pulses got %0d want 17", pulses); else n_pass++;
        n_total++; if (snap_count !== model_snap) $display("FAIL b2b_wrap got %0d want %0d", snap_count, model_snap); else n_pass++;
    endtask

`ifdef AXIS_SNAPSHOT_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int wc;
        cfg_delay   = '0;
        cfg_timeout = 8'd100;
        do_arm();
        wc = 0;
        while (sts_state === c_ST_WAIT_TRIG && wc < 300) begin
            wc++;
            step();
        end
        n_total++; if (wc !== 100) $display("FAIL tmo_len got %0d want 100", wc); else n_pass++;
        n_total++; if (sts_state !== c_ST_DELAY) $display("FAIL tmo_state got %0d want %0d", sts_state, c_ST_DELAY); else n_pass++;
        n_total++; if (sts_timeout !== 1'b1) $display("FAIL tmo_flag got %b want 1", sts_timeout); else n_pass++;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h3000_0001;
        expect_capture(32'h3000_0001);
        step();
        s_axis_tvalid = 1'b0;
        n_total++; if (sts_timeout !== 1'b1) $display("FAIL tmo_sticky got %b want 1", sts_timeout); else n_pass++;
        cfg_timeout = '0;
        do_arm();
        n_total++; if (sts_timeout !== 1'b0) $display("FAIL tmo_clear got %b want 0", sts_timeout); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_shot();
        test_delay_gaps();
        test_periodic();
        test_abort_arm();
        test_reset_mid_delay();
        test_max_delay();
        test_back_to_back();
`ifdef AXIS_SNAPSHOT_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) step();
        n_total++; if (q_data.size() != 0) $display("FAIL scoreboard_drain left %0d want 0", q_data.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
